shift_rows_pipe: RTL and testbench
==================================

Name: shift_rows_pipe

Overview:
- Parametrised, pipelined successor to the combinational AES ShiftRows stage.
- Supports Rijndael block widths of NB = 4, 6 or 8 columns, with a per-transaction operation: pass-through, forward ShiftRows or InvShiftRows.
- Has a valid/ready handshake, a configurable number of elastic register stages and a pass-through tag.
- Sits between SubBytes and MixColumns in the round datapath, and can be reused in the decrypt path.

Parameters:
- NB, 4: state columns. Legal values are 4, 6 and 8; any other value is an elaboration error. Data width is 32*NB.
- STAGES, 1: number of pipeline register stages, 1..4. Latency is STAGES cycles.
- TAG_W, 4: width of the sideband tag carried alongside each block.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input block valid.
- in_ready  out  1  stage can accept a block.
- in_op  in  2  operation: 00 PASS, 01 FWD, 10 INV, 11 reserved (treated as PASS).
- in_tag  in  TAG_W  sideband tag.
- in_data  in  32*NB  state in FIPS-197 byte order.
- out_valid  out  1  output block valid.
- out_ready  in  1  downstream accepts.
- out_tag  out  TAG_W  tag of the output block.
- out_data  out  32*NB  transformed state.

Behaviour:
- Byte mapping:
  - byte k occupies bits [32*NB-1-8k -: 8]; s[r][c] = byte r+4c.
  - FWD: out[r][c] = s[r][(c+off(r)) mod NB].
  - INV: out[r][c] = s[r][(c-off(r)) mod NB].
  - PASS: out = in.
- Row offsets: NB=4 or 6 → off = {0,1,2,3}; NB=8 → off = {0,1,3,4}.
- Transform placement: the transform is applied combinationally before stage 0. Stages 1..STAGES-1 only register data.
- Handshake:
  - A transfer occurs on a clk edge where valid&&ready.
  - Once asserted, out_valid, out_data and out_tag hold stable until out_ready.
  - in_ready never depends combinationally on in_valid.
- Pipeline:
  - Each stage holds vld[i], data[i] and tag[i].
  - Stage i advances when !vld[i] || stage i+1 advances.
  - The last stage advances on out_ready.
  - in_ready = stage 0 advance condition, so bubbles collapse.
  - Throughput is 1 block/cycle when out_ready is held high.
- Latency: a block accepted at edge N presents out_valid after edge N+STAGES-1 (visible in the cycle following edge N+STAGES-1), provided no stall occurs.
- Full condition: with out_ready low, exactly STAGES blocks are accepted, then in_ready deasserts. No block is ever dropped or duplicated.
- Simultaneous events: when full and out_ready=1, an in_valid in the same cycle is accepted (pass-through advance).
- Reset:
  - When reset_n=0 at a clk edge, all vld clear, so out_valid=0, and out_data and out_tag go to 0.
  - in_ready reads 1 in the cycle after reset.
  - Reset mid-operation discards in-flight blocks with no partial output.
- Reserved op 11 is treated as PASS; no error flag is raised.

Decomposition:
- Package aes_pkg holds:
  - typedef enum logic [1:0] op_t {OP_PASS, OP_FWD, OP_INV};
  - function row_offset(nb, r);
  - typedef logic [7:0] byte_t.
- Sub-module shift_rows_nb (combinational, parameter NB, inputs data and op) implements the byte permutation.
- shift_rows_pipe instantiates shift_rows_nb once and generates the STAGES elastic registers.

Test Plan:
- NB=4, STAGES=1, FWD, in_data=D42711AEE0BF98F1B8B45DE51E415230 → out_data=D4BF5D30E0B452AEB84111F11E2798E5, one cycle after acceptance.
- NB=4, INV on D4BF5D30E0B452AEB84111F11E2798E5 → D42711AEE0BF98F1B8B45DE51E415230. PASS and op=11 return the input unchanged.
- NB=8, FWD, in_data bytes 00..1F ascending → out_data begins 00050E13_04091217_…; the INV of that result returns the original bytes.
- STAGES=2, out_ready=0, stream tags 1,2,3 → only tags 1,2 accepted and in_ready=0. Raise out_ready → tags emerge in order 1,2,3 with no gaps once tag 3 enters.
- STAGES=3, continuous in_valid and out_ready=1 with 8 FWD blocks → 8 outputs on consecutive cycles, first output after edge N+2. Random out_ready toggling preserves order and data, checked by a scoreboard.
- Assert reset_n=0 with 2 blocks in flight → next cycle out_valid=0, out_data=0, in_ready=1. No stale block appears after reset is released.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and the Rijndael row-offset rule used by the ShiftRows datapath.
package aes_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    OP_PASS = 2'b00,
    OP_FWD  = 2'b01,
    OP_INV  = 2'b10
  } op_t;

  // Row 0..3 rotation amount; the 8-column block skips offset 2.
  function automatic int row_offset(input int nb, input int r);
    return (nb == 8 && r >= 2) ? r + 1 : r;
  endfunction

endpackage

// File: rtl/shift_rows_nb.sv
// Combinational ShiftRows / InvShiftRows byte permutation for an NB-column state.
module shift_rows_nb
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [32*NB-1:0] data_i,
  input  logic [1:0]       op_i,
  output logic [32*NB-1:0] data_o
);

  localparam int W = 32 * NB;

  byte_t src [4*NB];
  byte_t fwd [4*NB];
  byte_t inv [4*NB];

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int K  = r + 4 * c;
      localparam int FC = (c + row_offset(NB, r)) % NB;
      localparam int IC = (c + NB - row_offset(NB, r)) % NB;
      assign src[K] = data_i[W-1-8*K -: 8];
      assign fwd[K] = src[r + 4*FC];
      assign inv[K] = src[r + 4*IC];
    end
  end

  // Reserved op 2'b11 falls through as pass-through.
  always_comb begin
    data_o = data_i;
    for (int k = 0; k < 4*NB; k++) begin
      if (op_i == OP_FWD) begin
        data_o[W-1-8*k -: 8] = fwd[k];
      end else if (op_i == OP_INV) begin
        data_o[W-1-8*k -: 8] = inv[k];
      end
    end
  end

endmodule

// File: rtl/shift_rows_pipe.sv
// Elastic valid/ready pipeline around the ShiftRows permutation; the transform
// sits in front of stage 0 and later stages only re-register the block.
module shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int NB     = 4,
  parameter int STAGES = 1,
  parameter int TAG_W  = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic [32*NB-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [TAG_W-1:0]   out_tag,
  output logic [32*NB-1:0]   out_data
);

  localparam int W = 32 * NB;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("shift_rows_pipe: STAGES must be 1..4");
  end

  logic [W-1:0] xform;

  shift_rows_nb #(.NB(NB)) u_xform (
    .data_i (in_data),
    .op_i   (in_op),
    .data_o (xform)
  );

  logic [STAGES-1:0] vld_q, vld_d, adv;
  logic [W-1:0]      data_q [STAGES];
  logic [W-1:0]      data_d [STAGES];
  logic [TAG_W-1:0]  tag_q  [STAGES];
  logic [TAG_W-1:0]  tag_d  [STAGES];

  // Advance ripples back from the output so empty stages absorb bubbles.
  always_comb begin
    logic go;
    adv = '0;
    go  = !vld_q[STAGES-1] || out_ready;
    adv[STAGES-1] = go;
    for (int i = STAGES - 2; i >= 0; i--) begin
      go     = !vld_q[i] || go;
      adv[i] = go;
    end
  end

  always_comb begin
    vld_d  = '0;
    data_d = '{default: '0};
    tag_d  = '{default: '0};
    vld_d[0]  = in_valid;
    data_d[0] = xform;
    tag_d[0]  = in_tag;
    for (int i = 1; i < STAGES; i++) begin
      vld_d[i]  = vld_q[i-1];
      data_d[i] = data_q[i-1];
      tag_d[i]  = tag_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (adv[i]) begin
          vld_q[i]  <= vld_d[i];
          data_q[i] <= data_d[i];
          tag_q[i]  <= tag_d[i];
        end
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = vld_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Self-checking bench for shift_rows_pipe across NB=4/8/6 and STAGES=1/2/3.
module tb_shift_rows_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // A: NB=4, STAGES=1
  logic a_iv, a_ir, a_ov, a_or;
  logic [1:0] a_op;
  logic [3:0] a_it, a_ot;
  logic [127:0] a_id, a_od;
  // B: NB=8, STAGES=2
  logic b_iv, b_ir, b_ov, b_or;
  logic [1:0] b_op;
  logic [3:0] b_it, b_ot;
  logic [255:0] b_id, b_od;
  // C: NB=6, STAGES=3
  logic c_iv, c_ir, c_ov, c_or;
  logic [1:0] c_op;
  logic [7:0] c_it, c_ot;
  logic [191:0] c_id, c_od;

  shift_rows_pipe #(.NB(4), .STAGES(1), .TAG_W(4)) u_a (
    .clk(clk), .reset_n(rst_n), .in_valid(a_iv), .in_ready(a_ir), .in_op(a_op),
    .in_tag(a_it), .in_data(a_id), .out_valid(a_ov), .out_ready(a_or),
    .out_tag(a_ot), .out_data(a_od));
  shift_rows_pipe #(.NB(8), .STAGES(2), .TAG_W(4)) u_b (
    .clk(clk), .reset_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .in_op(b_op),
    .in_tag(b_it), .in_data(b_id), .out_valid(b_ov), .out_ready(b_or),
    .out_tag(b_ot), .out_data(b_od));
  shift_rows_pipe #(.NB(6), .STAGES(3), .TAG_W(8)) u_c (
    .clk(clk), .reset_n(rst_n), .in_valid(c_iv), .in_ready(c_ir), .in_op(c_op),
    .in_tag(c_it), .in_data(c_id), .out_valid(c_ov), .out_ready(c_or),
    .out_tag(c_ot), .out_data(c_od));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: view the block as a 4 x nb byte matrix and rotate each row.
  function automatic logic [255:0] model(input int nb, input logic [1:0] op,
                                         input logic [255:0] din);
    logic [7:0] s [4][8];
    int off [4];
    int src;
    logic [255:0] res = '0;
    if (nb == 8) off = '{0, 1, 3, 4};
    else         off = '{0, 1, 2, 3};
    for (int row = 0; row < 4; row++)
      for (int col = 0; col < nb; col++)
        s[row][col] = din[32*nb-1-8*(row+4*col) -: 8];
    for (int row = 0; row < 4; row++)
      for (int col = 0; col < nb; col++) begin
        case (op)
          2'b01:   src = (col + off[row]) % nb;
          2'b10:   src = (col - off[row] + nb) % nb;
          default: src = col;
        endcase
        res[32*nb-1-8*(row+4*col) -: 8] = s[row][src];
      end
    return res;
  endfunction

  function automatic logic [255:0] rnd256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int           nb;
    logic [1:0]   op;
    logic [255:0] din;
    logic [255:0] dout;
  } vec_t;
  vec_t vecs[$];

  task automatic apply_a(input string name, input logic [1:0] op, input logic [127:0] d,
                         input logic [3:0] tag, input logic [127:0] exp);
    a_op = op; a_id = d; a_it = tag; a_iv = 1'b1;
    chk({name, "_rdy"}, 256'(a_ir), 256'(1));
    step();
    a_iv = 1'b0;
    chk({name, "_vld"}, 256'(a_ov), 256'(1));
    chk({name, "_data"}, 256'(a_od), 256'(exp));
    chk({name, "_tag"}, 256'(a_ot), 256'(tag));
    step();
  endtask

  task automatic apply_b(input string name, input logic [1:0] op, input logic [255:0] d,
                         input logic [3:0] tag, input logic [255:0] exp);
    b_op = op; b_id = d; b_it = tag; b_iv = 1'b1;
    chk({name, "_rdy"}, 256'(b_ir), 256'(1));
    step();
    b_iv = 1'b0;
    chk({name, "_early"}, 256'(b_ov), 256'(0));
    step();
    chk({name, "_vld"}, 256'(b_ov), 256'(1));
    chk({name, "_data"}, b_od, exp);
    chk({name, "_tag"}, 256'(b_ot), 256'(tag));
    step();
  endtask

  logic [191:0] exp_d_q[$];
  logic [7:0]   exp_t_q[$];

  task automatic run_c(input int nblk, input bit rnd, input int budget,
                       output int first_out, output int last_out, output int n_out);
    int sent = 0;
    int cyc = 0;
    bit hold = 1'b0;
    logic [191:0] hd;
    logic [7:0] ht;
    logic [255:0] t;
    first_out = -1; last_out = -1; n_out = 0;
    while ((sent < nblk || c_iv || exp_d_q.size() > 0) && cyc < budget) begin
      if (!c_iv && sent < nblk && (!rnd || $urandom_range(0, 3) != 0)) begin
        t = rnd256();
        c_id = t[191:0];
        c_it = 8'(sent);
        c_op = rnd ? 2'($urandom_range(0, 3)) : 2'b01;
        c_iv = 1'b1;
      end
      c_or = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (hold) begin
        chk("c_hold_vld", 256'(c_ov), 256'(1));
        chk("c_hold_data", 256'(c_od), 256'(hd));
        chk("c_hold_tag", 256'(c_ot), 256'(ht));
      end
      hold = c_ov && !c_or;
      hd = c_od; ht = c_ot;
      if (c_ov && c_or) begin
        if (exp_d_q.size() == 0) begin
          chk("c_underflow", 256'(1), 256'(0));
        end else begin
          chk("c_sb_data", 256'(c_od), 256'(exp_d_q.pop_front()));
          chk("c_sb_tag", 256'(c_ot), 256'(exp_t_q.pop_front()));
        end
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        n_out++;
      end
      if (c_iv && c_ir) begin
        t = model(6, c_op, {64'b0, c_id});
        exp_d_q.push_back(t[191:0]);
        exp_t_q.push_back(c_it);
        sent++;
      end
      @(posedge clk);
      #1;
      if (c_iv && sent > 0 && c_it == 8'(sent - 1)) c_iv = 1'b0;
      cyc++;
    end
    chk("c_all_sent", 256'(sent), 256'(nblk));
    chk("c_sb_empty", 256'(exp_d_q.size()), 256'(0));
  endtask

  initial begin
    int f, l, n, seen;
    logic [255:0] r, d1, d2, d3;

    rst_n = 1'b0;
    a_iv = 0; a_op = 0; a_it = 0; a_id = 0; a_or = 1;
    b_iv = 0; b_op = 0; b_it = 0; b_id = 0; b_or = 1;
    c_iv = 0; c_op = 0; c_it = 0; c_id = 0; c_or = 1;
    step();
    step();
    chk("rst_a_vld", 256'(a_ov), 256'(0));
    chk("rst_a_data", 256'(a_od), 256'(0));
    chk("rst_b_rdy", 256'(b_ir), 256'(1));
    chk("rst_c_vld", 256'(c_ov), 256'(0));
    chk("rst_c_rdy", 256'(c_ir), 256'(1));
    rst_n = 1'b1;
    step();

    vecs.push_back(vec_t'{4, 2'b01, 256'hD42711AEE0BF98F1B8B45DE51E415230,
                                    256'hD4BF5D30E0B452AEB84111F11E2798E5});
    vecs.push_back(vec_t'{4, 2'b10, 256'hD4BF5D30E0B452AEB84111F11E2798E5,
                                    256'hD42711AEE0BF98F1B8B45DE51E415230});
    vecs.push_back(vec_t'{4, 2'b00, 256'hD42711AEE0BF98F1B8B45DE51E415230,
                                    256'hD42711AEE0BF98F1B8B45DE51E415230});
    vecs.push_back(vec_t'{4, 2'b11, 256'hD4BF5D30E0B452AEB84111F11E2798E5,
                                    256'hD4BF5D30E0B452AEB84111F11E2798E5});
    vecs.push_back(vec_t'{8, 2'b01,
      256'h00010203_04050607_08090A0B_0C0D0E0F_10111213_14151617_18191A1B_1C1D1E1F,
      256'h00050E13_04091217_080D161B_0C111A1F_10151E03_14190207_181D060B_1C010A0F});
    vecs.push_back(vec_t'{8, 2'b10,
      256'h00050E13_04091217_080D161B_0C111A1F_10151E03_14190207_181D060B_1C010A0F,
      256'h00010203_04050607_08090A0B_0C0D0E0F_10111213_14151617_18191A1B_1C1D1E1F});
    vecs.push_back(vec_t'{8, 2'b11,
      256'h00050E13_04091217_080D161B_0C111A1F_10151E03_14190207_181D060B_1C010A0F,
      256'h00050E13_04091217_080D161B_0C111A1F_10151E03_14190207_181D060B_1C010A0F});
    for (int i = 0; i < 12; i++) begin
      r = rnd256();
      if (i % 2 == 0) r[255:128] = '0;
      f = (i % 2 == 0) ? 4 : 8;
      vecs.push_back(vec_t'{f, 2'(i % 4), r, model(f, 2'(i % 4), r)});
    end
    foreach (vecs[i]) begin
      if (vecs[i].nb == 4)
        apply_a($sformatf("vec%0d", i), vecs[i].op, vecs[i].din[127:0], 4'(i),
                vecs[i].dout[127:0]);
      else
        apply_b($sformatf("vec%0d", i), vecs[i].op, vecs[i].din, 4'(i), vecs[i].dout);
    end

    // Fill B with out_ready low, then release with a third block waiting.
    d1 = rnd256(); d2 = rnd256(); d3 = rnd256();
    b_or = 1'b0; b_op = 2'b01;
    b_iv = 1'b1; b_it = 4'd1; b_id = d1;
    step();
    chk("full_rdy_after1", 256'(b_ir), 256'(1));
    b_it = 4'd2; b_id = d2;
    step();
    b_it = 4'd3; b_id = d3;
    chk("full_rdy_after2", 256'(b_ir), 256'(0));
    chk("full_head_tag", 256'(b_ot), 256'(1));
    step();
    step();
    chk("full_still_blocked", 256'(b_ir), 256'(0));
    chk("full_hold_tag", 256'(b_ot), 256'(1));
    chk("full_hold_data", b_od, model(8, 2'b01, d1));
    b_or = 1'b1;
    #1;
    chk("full_passthru_rdy", 256'(b_ir), 256'(1));
    step();
    b_iv = 1'b0;
    chk("drain_tag2", 256'(b_ot), 256'(2));
    chk("drain_data2", b_od, model(8, 2'b01, d2));
    step();
    chk("drain_vld3", 256'(b_ov), 256'(1));
    chk("drain_tag3", 256'(b_ot), 256'(3));
    chk("drain_data3", b_od, model(8, 2'b01, d3));
    step();
    chk("drain_empty", 256'(b_ov), 256'(0));

    run_c(8, 1'b0, 200, f, l, n);
    chk("thru_first_cycle", 256'(f), 256'(3));
    chk("thru_last_cycle", 256'(l), 256'(10));
    chk("thru_count", 256'(n), 256'(8));

    run_c(40, 1'b1, 2000, f, l, n);
    chk("rand_count", 256'(n), 256'(40));

    // Reset with two blocks in flight in C.
    c_or = 1'b0; c_op = 2'b01;
    c_iv = 1'b1; c_it = 8'hA1; c_id = rnd256();
    step();
    c_it = 8'hA2; c_id = rnd256();
    step();
    c_iv = 1'b0;
    rst_n = 1'b0;
    step();
    chk("rst_mid_vld", 256'(c_ov), 256'(0));
    chk("rst_mid_data", 256'(c_od), 256'(0));
    chk("rst_mid_tag", 256'(c_ot), 256'(0));
    chk("rst_mid_rdy", 256'(c_ir), 256'(1));
    rst_n = 1'b1;
    c_or = 1'b1;
    seen = 0;
    repeat (6) begin
      step();
      if (c_ov) seen++;
    end
    chk("rst_no_stale", 256'(seen), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
